store_buffer: RTL

Parametrised store path between the memory-stage store logic and the data-memory write port. It decodes store size and address into byte strobes and lane-aligned write data, and detects misaligned stores as an address-error exception. Accepted stores are queued in a DEPTH-entry FIFO with write-combining into the youngest entry, and drained to memory over a valid/ready handshake. It also flags loads that hit a pending store so the pipeline can stall.

---
 rtl/store_pkg.sv | 29 ++
 rtl/store_lane_gen.sv | 81 ++++++++
 rtl/store_buffer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/store_pkg.sv
// store_pkg: store size encodings and bus-geometry helpers shared by the store path.
// Revision 1.0
`default_nettype none

package store_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } size_e;

  localparam int DEFAULT_DATA_W = 32;
  localparam int STRB_W         = DEFAULT_DATA_W / 8;
  localparam int OFF_W          = $clog2(STRB_W);

  // Geometry for a non-default bus width; modules call these with their own DATA_W.
  function automatic int strb_w_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int off_w_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

`default_nettype wire

// File: rtl/store_lane_gen.sv
// store_lane_gen: decodes store size/offset into byte strobes, lane-aligned data and misalignment.
// Revision 1.0
`default_nettype none

module store_lane_gen
  import store_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int BIG_ENDIAN = 0
) (
  input  logic [1:0]          size,
  input  logic [2:0]          addr_lo,
  input  logic [DATA_W-1:0]   data,
  output logic [DATA_W/8-1:0] strb,
  output logic [DATA_W-1:0]   wdata,
  output logic                misalign
);

  localparam int LANES = strb_w_of(DATA_W);
  localparam int OFFS  = off_w_of(DATA_W);

  logic [7:0]        byte_mask;
  logic [LANES-1:0]  size_mask;
  logic [LANES-1:0]  strb_le;
  logic [DATA_W-1:0] data_m;
  logic [DATA_W-1:0] data_le;
  logic [OFFS-1:0]   off;

  assign off = addr_lo[OFFS-1:0];

  always_comb begin
    byte_mask = 8'h01;
    misalign  = 1'b0;
    case (size)
      SIZE_B: begin
        byte_mask = 8'h01;
        misalign  = 1'b0;
      end
      SIZE_H: begin
        byte_mask = 8'h03;
        misalign  = addr_lo[0];
      end
      SIZE_W: begin
        byte_mask = 8'h0F;
        misalign  = (addr_lo[1:0] != 2'b00);
      end
      default: begin
        byte_mask = 8'hFF;
        misalign  = (DATA_W == 32) || (addr_lo != 3'b000);
      end
    endcase
  end

  assign size_mask = LANES'(byte_mask);

  // Clear bytes above the access size so unstrobed lanes carry zeros.
  always_comb begin
    data_m = '0;
    for (int b = 0; b < LANES; b++) begin
      data_m[8*b +: 8] = size_mask[b] ? data[8*b +: 8] : 8'h00;
    end
  end

  assign strb_le = size_mask << off;
  assign data_le = data_m << {off, 3'b000};

  generate
    if (BIG_ENDIAN != 0) begin : g_big
      for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign strb[j]          = strb_le[LANES-1-j];
        assign wdata[8*j +: 8]  = data_le[8*(LANES-1-j) +: 8];
      end
    end else begin : g_little
      assign strb  = strb_le;
      assign wdata = data_le;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// store_buffer: store FIFO with tail write-combining, misalign trapping and load-hit detection.
// Revision 1.0
`default_nettype none

module store_buffer
  import store_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH      = 4,
  parameter int BIG_ENDIAN = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_size,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_data,
  output logic                       addr_err,
  output logic [ADDR_W-1:0]          err_addr,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [DATA_W/8-1:0]        mem_wstrb,
  input  logic                       ld_valid,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic                       ld_hit,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int LANES = strb_w_of(DATA_W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LANES - 1);

  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [LANES-1:0]  ent_strb [DEPTH];
  logic [DEPTH-1:0]  ent_valid;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, tail_ptr;

  logic [LANES-1:0]  lane_strb;
  logic [DATA_W-1:0] lane_data;
  logic              misalign;
  logic [ADDR_W-1:0] req_aligned, ld_aligned;
  logic [DATA_W-1:0] merge_data;
  logic              full, merge_cand, accept, push, merge, pop, ld_any;

  store_lane_gen #(
    .DATA_W     (DATA_W),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_lane_gen (
    .size     (req_size),
    .addr_lo  (req_addr[2:0]),
    .data     (req_data),
    .strb     (lane_strb),
    .wdata    (lane_data),
    .misalign (misalign)
  );

  assign req_aligned = req_addr & ALIGN_MASK;
  assign ld_aligned  = ld_addr & ALIGN_MASK;
  assign tail_ptr    = wr_ptr - PTR_W'(1);
  assign full        = (count == CNT_W'(DEPTH));

  // count>=2 guarantees the tail is not the head, so the presented beat never changes.
  assign merge_cand  = (count >= CNT_W'(2)) && (ent_addr[tail_ptr] == req_aligned);
  assign req_ready   = !full || merge_cand || misalign;
  assign accept      = req_valid && req_ready;
  assign push        = accept && !misalign && !merge_cand;
  assign merge       = accept && !misalign && merge_cand;
  assign pop         = mem_valid && mem_ready;

  assign mem_valid   = (count != '0);
  assign empty       = (count == '0);
  assign mem_addr    = ent_addr[rd_ptr];
  assign mem_wdata   = ent_data[rd_ptr];
  assign mem_wstrb   = ent_strb[rd_ptr];

  always_comb begin
    merge_data = ent_data[tail_ptr];
    for (int b = 0; b < LANES; b++) begin
      if (lane_strb[b]) merge_data[8*b +: 8] = lane_data[8*b +: 8];
    end
  end

  always_comb begin
    ld_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i] == ld_aligned)) ld_any = 1'b1;
    end
  end

  assign ld_hit = ld_valid && ld_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
        ent_strb[i] <= '0;
      end
      ent_valid <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      addr_err  <= 1'b0;
      err_addr  <= '0;
    end else begin
      addr_err <= accept && misalign;
      if (accept && misalign) err_addr <= req_addr;

      if (push) begin
        ent_addr[wr_ptr]  <= req_aligned;
        ent_data[wr_ptr]  <= lane_data;
        ent_strb[wr_ptr]  <= lane_strb;
        ent_valid[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end

      if (merge) begin
        ent_data[tail_ptr] <= merge_data;
        ent_strb[tail_ptr] <= ent_strb[tail_ptr] | lane_strb;
      end

      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + PTR_W'(1);
      end

      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

endmodule

`default_nettype wire
